sio_pad_ctrl_seq: RTL

- Core-side sequencer that drives the configuration and data inputs of one SIO pad and samples its IN output back into the core clock domain.
- Guarantees glitch-safe reconfiguration: the driver is tristated around every DM/mode change.
- Sequences pad enable and hold-mode entry/exit, including hold-override pass-through.
- Sits between the GPIO register block and the pad cell; all pad-facing outputs are registered.

---
 rtl/sio_pad_ctrl_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sio_pad_ctrl_seq.sv
// Core-side sequencer for one SIO pad: sequences enable, glitch-safe
// reconfiguration (driver tristated around every mode change) and hold
// entry/exit, and synchronizes the pad IN signal into the core clock domain.
module sio_pad_ctrl_seq #(
  parameter int SETTLE_CYCLES = 4,  // 1..255, cycles per sequencing phase
  parameter int SYNC_STAGES   = 2   // 2..4, IN synchronizer depth
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pad_en_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [2:0] cfg_dm_i,
  input  logic       cfg_inp_dis_i,
  input  logic       cfg_slow_i,
  input  logic       cfg_vtrip_sel_i,
  input  logic       cfg_ibuf_sel_i,
  input  logic       cfg_vreg_en_i,
  output logic       cfg_err_o,
  input  logic       out_req_i,
  input  logic       oe_n_req_i,
  input  logic       hold_req_i,
  input  logic       hold_ovr_req_i,
  output logic       enable_h_o,
  output logic       hld_h_n_o,
  output logic       hld_ovr_o,
  output logic       out_o,
  output logic       oe_n_o,
  output logic       inp_dis_o,
  output logic       slow_o,
  output logic       vtrip_sel_o,
  output logic       ibuf_sel_o,
  output logic       vreg_en_o,
  output logic [2:0] dm_o,
  input  logic       in_i,
  output logic       in_sync_o,
  output logic       in_hold_o
);

  typedef enum logic [2:0] {
    S_OFF, S_ENABLING, S_ACTIVE, S_RECFG_TRI, S_RECFG_APPLY, S_HOLD, S_HOLD_EXIT
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);
  // Mode word layout: {dm[2:0], inp_dis, slow, vtrip_sel, ibuf_sel, vreg_en};
  // the pad powers up with the input buffer disabled.
  localparam logic [7:0] MODE_RST = 8'b000_1_0000;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] shadow_q, shadow_d;
  logic       enable_h_q, enable_h_d;
  logic       hld_h_n_q, hld_h_n_d;
  logic       hld_ovr_q, hld_ovr_d;
  logic       out_q, out_d;
  logic       oe_n_q, oe_n_d;
  logic       cfg_err_q, cfg_err_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic [7:0] cfg_word;
  logic       cfg_legal;

  assign cfg_word  = {cfg_dm_i, cfg_inp_dis_i, cfg_slow_i, cfg_vtrip_sel_i,
                      cfg_ibuf_sel_i, cfg_vreg_en_i};
  // The regulator may only be enabled with a drive mode that tolerates it.
  assign cfg_legal = !cfg_vreg_en_i ||
                     (cfg_dm_i == 3'b011) || (cfg_dm_i == 3'b101) || (cfg_dm_i == 3'b110);

  // State, counter and all pad-facing output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_OFF;
      cnt_q      <= 8'd0;
      mode_q     <= MODE_RST;
      shadow_q   <= MODE_RST;
      enable_h_q <= 1'b0;
      hld_h_n_q  <= 1'b1;
      hld_ovr_q  <= 1'b0;
      out_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      shadow_q   <= shadow_d;
      enable_h_q <= enable_h_d;
      hld_h_n_q  <= hld_h_n_d;
      hld_ovr_q  <= hld_ovr_d;
      out_q      <= out_d;
      oe_n_q     <= oe_n_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    shadow_d   = shadow_q;
    enable_h_d = enable_h_q;
    hld_h_n_d  = hld_h_n_q;
    hld_ovr_d  = hld_ovr_q;
    out_d      = out_q;
    oe_n_d     = oe_n_q;
    cfg_err_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (pad_en_i) begin
          state_d    = S_ENABLING;
          enable_h_d = 1'b1;
          cnt_d      = CNT_LOAD;
        end
      end
      S_ENABLING: begin
        if (cnt_q == 8'd0) state_d = S_ACTIVE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ACTIVE: begin
        out_d  = out_req_i;
        oe_n_d = oe_n_req_i;
        if (!pad_en_i) begin
          // Power-down wins over hold and config; everything back to idle.
          state_d    = S_OFF;
          enable_h_d = 1'b0;
          hld_h_n_d  = 1'b1;
          hld_ovr_d  = 1'b0;
          out_d      = 1'b0;
          oe_n_d     = 1'b1;
          mode_d     = MODE_RST;
        end else if (hold_req_i) begin
          state_d   = S_HOLD;
          hld_h_n_d = 1'b0;
        end else if (cfg_valid_i) begin
          if (cfg_legal) begin
            shadow_d = cfg_word;
            oe_n_d   = 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = S_RECFG_TRI;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RECFG_TRI: begin
        out_d  = out_req_i;
        oe_n_d = 1'b1;
        if (cnt_q == 8'd0) begin
          mode_d  = shadow_q;
          cnt_d   = CNT_LOAD;
          state_d = S_RECFG_APPLY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RECFG_APPLY: begin
        out_d  = out_req_i;
        oe_n_d = 1'b1;
        if (cnt_q == 8'd0) state_d = S_ACTIVE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_HOLD: begin
        if (!hold_req_i) begin
          state_d   = S_HOLD_EXIT;
          hld_h_n_d = 1'b1;
          hld_ovr_d = 1'b0;
          cnt_d     = CNT_LOAD;
        end else begin
          hld_ovr_d = hold_ovr_req_i;
          // Data path only moves once the pad has actually seen HLD_OVR.
          if (hld_ovr_q) begin
            out_d  = out_req_i;
            oe_n_d = oe_n_req_i;
          end
        end
      end
      S_HOLD_EXIT: begin
        if (cnt_q == 8'd0) state_d = S_ACTIVE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_OFF;
    endcase
  end

  // IN synchronizer; held clear while the pad is not powered.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_h_q) sync_q <= '0;
    else                        sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  assign cfg_ready_o = (state_q == S_ACTIVE);
  assign in_hold_o   = (state_q == S_HOLD) || (state_q == S_HOLD_EXIT) ||
                       (state_q == S_ENABLING);
  assign cfg_err_o   = cfg_err_q;
  assign enable_h_o  = enable_h_q;
  assign hld_h_n_o   = hld_h_n_q;
  assign hld_ovr_o   = hld_ovr_q;
  assign out_o       = out_q;
  assign oe_n_o      = oe_n_q;
  assign dm_o        = mode_q[7:5];
  assign inp_dis_o   = mode_q[4];
  assign slow_o      = mode_q[3];
  assign vtrip_sel_o = mode_q[2];
  assign ibuf_sel_o  = mode_q[1];
  assign vreg_en_o   = mode_q[0];
  assign in_sync_o   = sync_q[SYNC_STAGES-1];

endmodule
